prbs5_stream_checker: RTL and testbench
=======================================

Name: prbs5_stream_checker

Overview:
- Receive-side companion to the 5-bit Fibonacci LFSR random source used by the Monte Carlo hardware.
- Consumes the 8-bit-per-word pseudo-random stream, self-synchronises to it, and declares lock.
- Once locked, counts bit errors and detects loss of sync.
- Used in bring-up and on-line health checks of the random-number path feeding the Hawkes sampler.

Parameters:
- LOCK_WORDS, 2: consecutive correctly predicted words required to enter LOCKED (range 1..15).
- LOSS_WORDS, 3: consecutive mismatching words in LOCKED that force return to HUNT (range 1..15).
- CNT_W, 16: width of the saturating error and word counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data carries a stream word this cycle.
- in_data  in  8  stream word; MSB is the oldest bit in time.
- clear_cnt  in  1  synchronous clear of err_count and word_count.
- locked  out  1  checker is in LOCKED.
- err_strobe  out  1  one-cycle pulse: the word just checked in LOCKED mismatched.
- err_bits  out  4  popcount of the mismatch for that word (0..8); held until the next checked word.
- err_count  out  CNT_W  accumulated bit errors in LOCKED; saturates at all-ones.
- word_count  out  CNT_W  words checked in LOCKED; saturates at all-ones.

Behaviour:
- Sequence definition: serial x[n] = x[n-5] XOR x[n-3] (x^5+x^3+1, period 31). Each word packs 8 consecutive bits, oldest in bit 7.
- Predictor:
  - 5-bit state holds the last 5 sequence bits.
  - The next-word function produces the 8 predicted bits and the advanced state.
- Reset: all outputs 0; state HUNT; predictor state 0; good_cnt and bad_cnt 0.
- All outputs are registered and update the cycle after the in_valid word. With in_valid=0, nothing changes and err_strobe=0.
- HUNT:
  - On a valid word, seed the predictor from in_data[4:0] and go to VERIFY with good_cnt=0.
  - If in_data[4:0]==0 (degenerate all-zero seed), stay in HUNT with no seed.
- VERIFY:
  - Compare in_data against the prediction.
  - On match: good_cnt++ and advance the predictor. If good_cnt reaches LOCK_WORDS, go to LOCKED with bad_cnt=0.
  - On mismatch: reseed from in_data[4:0] and set good_cnt=0. A zero seed sends the checker back to HUNT.
  - No counters or err_strobe activity in VERIFY.
- LOCKED:
  - The predictor free-runs from its own state and never reseeds from received data.
  - Every valid word increments word_count and drives err_bits = popcount(in_data XOR pred). err_count += err_bits (saturating).
  - A nonzero mismatch pulses err_strobe and increments bad_cnt. A zero mismatch clears bad_cnt.
  - When bad_cnt reaches LOSS_WORDS: go to HUNT and drop locked in the same registered update. That word's errors are still counted.
- clear_cnt has priority over a simultaneous increment: the counters become 0 and that word's increment is discarded. clear_cnt does not affect state or lock.
- Reset mid-stream: immediately to the reset state. Lock must be reacquired with 1 + LOCK_WORDS valid words.
- Saturation: counters hold at all-ones; the adder must not wrap.

Decomposition:
- Package prbs5_pkg:
  - state enum {HUNT, VERIFY, LOCKED}
  - TAP_A=5, TAP_B=3, WORD_W=8, SEED_W=5
  - the predict-word function (state in, 8-bit word and next state out)
- One sub-module: prbs5_word_predictor.
  - Registered 5-bit state.
  - load/advance inputs; combinational word output.
- Top-level FSM, counters and popcount stay in prbs5_stream_checker.

Test Plan:
- Stream from seed all-ones: 0xF8, 0xDD, 0x42 → locked=1 in the cycle after 0x42; err_count=0, word_count=0.
- Continue 0x59 with one flipped bit (send 0x58) → err_strobe=1, err_bits=1, err_count=1, word_count=1, locked stays 1. Resume with the correct period continuation → bad_cnt clears.
- After lock, send 0x00 three times → err_strobe pulses each word; err_count accumulates the popcount of each prediction; locked=0 after the third.
- From reset, send 0x00 repeatedly → stays HUNT, locked=0, no counter activity. Then 0xF8, 0xDD, 0x42 → locks.
- Assert clear_cnt together with an errored locked word → err_count=0, word_count=0 next cycle, locked unchanged. Preload near saturation (CNT_W=4 build) → counters stick at 15.
- Pulse rst_n low mid-LOCKED → all outputs 0 asynchronously. Relock requires 3 valid correct words.

Source files
------------

// File: rtl/prbs5_pkg.sv
// Shared definitions for the PRBS5 (x^5+x^3+1) stream checker: FSM states,
// sequence geometry and the word-at-a-time predictor function.
package prbs5_pkg;

  localparam int TAP_A  = 5;
  localparam int TAP_B  = 3;
  localparam int WORD_W = 8;
  localparam int SEED_W = 5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [SEED_W-1:0] next;
  } pred_t;

  // State bit SEED_W-1 is the oldest sequence bit; each new bit is
  // x[n-TAP_A] ^ x[n-TAP_B] and the first generated bit lands in word MSB.
  function automatic pred_t predict_word(input logic [SEED_W-1:0] s);
    pred_t             r;
    logic [SEED_W-1:0] st;
    logic              nb;
    r  = '0;
    st = s;
    for (int j = 0; j < WORD_W; j++) begin
      nb                   = st[SEED_W-TAP_A+TAP_A-1] ^ st[TAP_B-1+SEED_W-TAP_A];
      r.word[WORD_W-1-j]   = nb;
      st                   = {st[SEED_W-2:0], nb};
    end
    r.next = st;
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [WORD_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int j = 0; j < WORD_W; j++) begin
      c = c + {3'b000, v[j]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs5_word_predictor.sv
// Holds the last five PRBS5 bits and presents the next predicted 8-bit word
// combinationally; load reseeds, advance steps one word.
module prbs5_word_predictor
  import prbs5_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [SEED_W-1:0] seed,
  output logic [WORD_W-1:0] pred_word
);

  logic [SEED_W-1:0] st_p1;
  pred_t             pred_p0;

  assign pred_p0   = predict_word(st_p1);
  assign pred_word = pred_p0.word;

  // ---- stage p0 -> p1: predictor state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_p1 <= '0;
    end else if (load) begin
      st_p1 <= seed;
    end else if (advance) begin
      st_p1 <= pred_p0.next;
    end
  end

endmodule

// File: rtl/prbs5_stream_checker.sv
// Self-synchronising PRBS5 word-stream checker: hunts for a seed, verifies
// LOCK_WORDS predictions, then counts bit errors and detects loss of sync.
module prbs5_stream_checker
  import prbs5_pkg::*;
#(
  parameter int LOCK_WORDS = 2,
  parameter int LOSS_WORDS = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_strobe,
  output logic [3:0]       err_bits,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_WORDS);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_WORDS);

  // Saturating add: the carry out forces all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  chk_state_e  state_p1, state_nxt;
  logic [3:0]  good_cnt_p1, good_nxt;
  logic [3:0]  bad_cnt_p1, bad_nxt;
  logic        load, advance;
  logic [7:0]  pred_word;
  logic [7:0]  miss_p0;
  logic [3:0]  miss_bits_p0;
  logic        seed_ok_p0;
  logic        vld_p0;
  logic        chk_vld_p0;

  prbs5_word_predictor u_pred (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .seed      (in_data[SEED_W-1:0]),
    .pred_word (pred_word)
  );

  assign vld_p0       = in_valid;
  assign miss_p0      = in_data ^ pred_word;
  assign miss_bits_p0 = popcount8(miss_p0);
  assign seed_ok_p0   = |in_data[SEED_W-1:0];
  assign chk_vld_p0   = vld_p0 && (state_p1 == LOCKED);

  always_comb begin
    state_nxt = state_p1;
    good_nxt  = good_cnt_p1;
    bad_nxt   = bad_cnt_p1;
    load      = 1'b0;
    advance   = 1'b0;
    if (vld_p0) begin
      case (state_p1)
        HUNT: begin
          if (seed_ok_p0) begin
            load      = 1'b1;
            state_nxt = VERIFY;
            good_nxt  = '0;
          end
        end
        VERIFY: begin
          if (miss_p0 == '0) begin
            advance = 1'b1;
            if ((good_cnt_p1 + 4'd1) == LOCK_TGT) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              good_nxt = good_cnt_p1 + 4'd1;
            end
          end else begin
            good_nxt = '0;
            // A zero seed would lock the predictor into the all-zero trap.
            if (seed_ok_p0) begin
              load = 1'b1;
            end else begin
              state_nxt = HUNT;
            end
          end
        end
        LOCKED: begin
          advance = 1'b1;
          if (miss_p0 != '0) begin
            if ((bad_cnt_p1 + 4'd1) == LOSS_TGT) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt_p1 + 4'd1;
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: FSM, status and counter registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1    <= HUNT;
      good_cnt_p1 <= '0;
      bad_cnt_p1  <= '0;
      locked      <= 1'b0;
      err_strobe  <= 1'b0;
      err_bits    <= '0;
      err_count   <= '0;
      word_count  <= '0;
    end else begin
      state_p1    <= state_nxt;
      good_cnt_p1 <= good_nxt;
      bad_cnt_p1  <= bad_nxt;
      locked      <= (state_nxt == LOCKED);
      err_strobe  <= chk_vld_p0 && (miss_p0 != '0);
      if (chk_vld_p0) begin
        err_bits <= miss_bits_p0;
      end
      if (clear_cnt) begin
        err_count  <= '0;
        word_count <= '0;
      end else if (chk_vld_p0) begin
        err_count  <= sat_add(err_count, CNT_W'(miss_bits_p0));
        word_count <= sat_add(word_count, CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_prbs5_stream_checker.sv
// Directed bench for prbs5_stream_checker: a vector table for the main
// lock/error/loss flow plus hand sequences for reset, zero seed and saturation.
module tb_prbs5_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clear_cnt = 1'b0;

  logic        locked, err_strobe;
  logic [3:0]  err_bits;
  logic [15:0] err_count, word_count;

  logic        locked4, err_strobe4;
  logic [3:0]  err_bits4;
  logic [3:0]  err_count4, word_count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs5_stream_checker #(.LOCK_WORDS(2), .LOSS_WORDS(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_cnt(clear_cnt), .locked(locked), .err_strobe(err_strobe),
    .err_bits(err_bits), .err_count(err_count), .word_count(word_count)
  );

  prbs5_stream_checker #(.LOCK_WORDS(2), .LOSS_WORDS(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_cnt(clear_cnt), .locked(locked4), .err_strobe(err_strobe4),
    .err_bits(err_bits4), .err_count(err_count4), .word_count(word_count4)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       clr;
    logic       lk;
    logic       stb;
    logic [3:0] bits;
    int         err;
    int         words;
  } vec_t;

  vec_t tv[21];
  logic seq_bits[31];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic clr,
                              input logic lk, input logic stb, input logic [3:0] bits,
                              input int err, input int words);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.lk = lk; r.stb = stb;
    r.bits = bits; r.err = err; r.words = words;
    return r;
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  function automatic logic [7:0] word_at(input int k);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7-j] = seq_bits[(8*k + j) % 31];
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic lk, input logic stb,
                             input logic [3:0] bits, input int err, input int words);
    chk({tag, ".locked"},     int'(locked),      int'(lk));
    chk({tag, ".err_strobe"}, int'(err_strobe),  int'(stb));
    chk({tag, ".err_bits"},   int'(err_bits),    int'(bits));
    chk({tag, ".err_count"},  int'(err_count),   err);
    chk({tag, ".word_count"}, int'(word_count),  words);
    chk({tag, ".locked4"},    int'(locked4),     int'(lk));
    chk({tag, ".err_strobe4"},int'(err_strobe4), int'(stb));
    chk({tag, ".err_bits4"},  int'(err_bits4),   int'(bits));
    chk({tag, ".err_count4"}, int'(err_count4),  sat15(err));
    chk({tag, ".word_count4"},int'(word_count4), sat15(words));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    in_valid  = v;
    in_data   = d;
    clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  exp_err;
    int  exp_w;
    logic bad;
    logic [7:0] d;

    for (int n = 0; n < 5; n++) seq_bits[n] = 1'b1;
    for (int n = 5; n < 31; n++) seq_bits[n] = seq_bits[n-5] ^ seq_bits[n-3];

    //              v     data   clr   lk    stb   bits  err words
    tv[0]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 0,  0);
    tv[1]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 0,  0);
    tv[2]  = mk(1'b0, 8'hF8, 1'b0, 1'b0, 1'b0, 4'd0, 0,  0);
    tv[3]  = mk(1'b1, 8'hF8, 1'b0, 1'b0, 1'b0, 4'd0, 0,  0);
    tv[4]  = mk(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 4'd0, 0,  0);
    tv[5]  = mk(1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 4'd0, 0,  0);
    tv[6]  = mk(1'b1, 8'h58, 1'b0, 1'b1, 1'b1, 4'd1, 1,  1);
    tv[7]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1,  1);
    tv[8]  = mk(1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 4'd0, 1,  2);
    tv[9]  = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5, 6,  3);
    tv[10] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd2, 8,  4);
    tv[11] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 13, 5);
    tv[12] = mk(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 4'd5, 13, 5);
    tv[13] = mk(1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 4'd5, 13, 5);
    tv[14] = mk(1'b1, 8'hC5, 1'b0, 1'b0, 1'b0, 4'd5, 13, 5);
    tv[15] = mk(1'b1, 8'h9F, 1'b0, 1'b0, 1'b0, 4'd5, 13, 5);
    tv[16] = mk(1'b1, 8'h1B, 1'b0, 1'b1, 1'b0, 4'd5, 13, 5);
    tv[17] = mk(1'b1, 8'hA9, 1'b1, 1'b1, 1'b1, 4'd1, 0,  0);
    tv[18] = mk(1'b1, 8'h4B, 1'b0, 1'b1, 1'b0, 4'd0, 0,  1);
    tv[19] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 0,  0);
    tv[20] = mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5, 5,  1);

    #2;
    chk_outputs("reset", 1'b0, 1'b0, 4'd0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].v, tv[i].d, tv[i].clr);
      chk_outputs($sformatf("vec%0d", i), tv[i].lk, tv[i].stb, tv[i].bits,
                  tv[i].err, tv[i].words);
    end

    // Asynchronous reset while locked with nonzero status.
    rst_n = 1'b0;
    #2;
    chk_outputs("async_rst", 1'b0, 1'b0, 4'd0, 0, 0);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'hF8, 1'b0);
    chk_outputs("relock0", 1'b0, 1'b0, 4'd0, 0, 0);
    drive(1'b1, 8'hDD, 1'b0);
    chk_outputs("relock1", 1'b0, 1'b0, 4'd0, 0, 0);
    drive(1'b1, 8'h42, 1'b0);
    chk_outputs("relock2", 1'b1, 1'b0, 4'd0, 0, 0);

    // Zero seed from a VERIFY mismatch must fall back to HUNT.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'hF8, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    chk_outputs("zseed0", 1'b0, 1'b0, 4'd0, 0, 0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    chk_outputs("zseed1", 1'b0, 1'b0, 4'd0, 0, 0);
    drive(1'b1, 8'hF8, 1'b0);
    drive(1'b1, 8'hDD, 1'b0);
    drive(1'b1, 8'h42, 1'b0);
    chk_outputs("zseed_lock", 1'b1, 1'b0, 4'd0, 0, 0);

    // Saturation: every third word fully inverted, others correct.
    exp_err = 0;
    exp_w   = 0;
    for (int i = 0; i < 20; i++) begin
      d   = word_at(3 + i);
      bad = (i % 3 == 0);
      if (bad) d = ~d;
      drive(1'b1, d, 1'b0);
      exp_w++;
      if (bad) exp_err += 8;
      chk_outputs($sformatf("sat%0d", i), 1'b1, bad, bad ? 4'd8 : 4'd0, exp_err, exp_w);
    end
    chk("sat_final.err_count4", int'(err_count4), 15);
    chk("sat_final.word_count4", int'(word_count4), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
